mtr_seq_ctrl: RTL
=================

MTR_SEQ_CTRL -- requirements
Module: mtr_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1024: clocks per ramp tick (range 2..65535).
REQ-002 SHALL have parameter STEP, default 12'd8: maximum per-tick change of each speed output (range 1..2047).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  drive enable request (rider present / power up), synchronous.
REQ-006 lft_tgt  input  12  target left speed, signed two's complement.
REQ-007 rght_tgt  input  12  target right speed, signed two's complement.
REQ-008 OVR_I_shtdwn  input  1  latched over-current shutdown from the motor driver.
REQ-009 flt_clr  input  1  fault clear request, level.
REQ-010 lft_spd  output  12  slew-limited left speed command to the motor driver, signed, registered.
REQ-011 rght_spd  output  12  slew-limited right speed command to the motor driver, signed, registered.
REQ-012 drv_en  output  1  high in RUN and STOP states only, registered.
REQ-013 fault  output  1  high in FAULT state only, registered.

Function
REQ-014 Tick counter SHALL count 0..TICK_DIV-1 free-running and wrap to 0; tick SHALL be asserted for one clock when count == TICK_DIV-1.
REQ-015 FSM states SHALL be IDLE, RUN, STOP, FAULT.
REQ-016 IDLE: lft_spd = rght_spd = 0; en=1 -> RUN on next clock.
REQ-017 RUN: on each tick, each output SHALL move toward its target by min(|tgt - spd|, STEP); no change between ticks; en=0 -> STOP.
REQ-018 STOP: on each tick, each output SHALL move toward 0 by min(|spd|, STEP); when both outputs are 0 -> IDLE; en=1 -> RUN (ramp resumes from current values, no discontinuity).
REQ-019 Any state with OVR_I_shtdwn=1 -> FAULT on next clock; this transition SHALL have priority over all others.
REQ-020 Entry into FAULT SHALL clear lft_spd and rght_spd to 0 on the same clock as the state transition (no ramp).
REQ-021 FAULT -> IDLE only when flt_clr=1 AND OVR_I_shtdwn=0 AND en=0 in the same cycle; otherwise remain in FAULT.
REQ-022 Difference tgt - spd SHALL be computed at 13-bit signed width; outputs SHALL never overshoot the target and never wrap (full range -2048..2047).
REQ-023 Target changes mid-ramp SHALL take effect at the next tick; no latching of targets.
REQ-024 Tick coincident with a state transition: the update on that clock SHALL use the current (pre-transition) state's ramp rule; FAULT entry overrides to 0.
REQ-025 Left and right channels SHALL ramp independently; one reaching target SHALL not stall the other.

Reset
REQ-026 On rst_n low: state = IDLE, tick counter = 0, lft_spd = rght_spd = 0, drv_en = 0, fault = 0, asynchronously.
REQ-027 Reset asserted mid-ramp or in FAULT SHALL return to the reset values above; on release the block SHALL start in IDLE.

Verification (TICK_DIV=4, STEP=8)
REQ-028 en=1, lft_tgt=20, rght_tgt=-20 -> lft_spd 8,16,20 and rght_spd -8,-16,-20 on successive ticks (4 clocks apart); drv_en=1.
REQ-029 In RUN at lft_spd=rght_spd=20, drop en -> STOP; outputs 12,4,0 on ticks; IDLE and drv_en=0 one clock after both reach 0.
REQ-030 lft_tgt=2047 from 2040, then lft_tgt=-2048 -> spd reaches 2047 without overshoot, then descends by 8 per tick to -2048 without wrap.
REQ-031 OVR_I_shtdwn pulses high at lft_spd=100 -> next clock FAULT, outputs 0, fault=1, drv_en=0; flt_clr=1 with en=1 ignored; flt_clr=1 with en=0, shtdwn=0 -> IDLE.
REQ-032 Assert rst_n=0 mid-ramp at lft_spd=48 -> outputs 0 immediately, state IDLE; release with en=1 -> ramp restarts from 0.
REQ-033 In STOP at spd=16, re-assert en=1 with tgt=40 -> RUN, ramp continues 24,32,40 without returning to 0.

Source files
------------

// File: rtl/mtr_seq_ctrl.sv
// Motor speed sequencer: enable/stop/fault FSM with per-tick slew-limited
// left/right speed commands.
module mtr_seq_ctrl #(
    parameter int unsigned TICK_DIV = 1024,
    parameter logic [11:0] STEP     = 12'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] lft_tgt,
    input  logic [11:0] rght_tgt,
    input  logic        OVR_I_shtdwn,
    input  logic        flt_clr,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        drv_en,
    output logic        fault
);

    typedef enum logic [1:0] {StIdle, StRun, StStop, StFault} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic        drv_en_q, drv_en_d;
    logic        fault_q, fault_d;
    logic        tick;

    // Step spd toward tgt by at most STEP; the result always lies between spd
    // and tgt, so the 12-bit truncation can never wrap.
    function automatic logic [11:0] ramp(input logic [11:0] spd, input logic [11:0] tgt);
        logic signed [12:0] diff;
        logic signed [12:0] step_s;
        logic [11:0]        res;
        step_s = $signed({1'b0, STEP});
        diff   = $signed({tgt[11], tgt}) - $signed({spd[11], spd});
        if (diff > step_s) begin
            res = spd + STEP;
        end else if (diff < -step_s) begin
            res = spd - STEP;
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    assign tick  = (cnt_q == 16'(TICK_DIV - 1));
    assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        case (state_q)
            StIdle: begin
                lft_d  = 12'd0;
                rght_d = 12'd0;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (tick) begin
                    lft_d  = ramp(lft_q, lft_tgt);
                    rght_d = ramp(rght_q, rght_tgt);
                end
                if (!en) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    lft_d  = ramp(lft_q, 12'd0);
                    rght_d = ramp(rght_q, 12'd0);
                end
                if (en) begin
                    state_d = StRun;
                end else if (lft_q == 12'd0 && rght_q == 12'd0) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                lft_d  = 12'd0;
                rght_d = 12'd0;
                if (flt_clr && !OVR_I_shtdwn && !en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                lft_d   = 12'd0;
                rght_d  = 12'd0;
            end
        endcase
        // Over-current wins over every other transition and zeroes outputs at once.
        if (OVR_I_shtdwn) begin
            state_d = StFault;
            lft_d   = 12'd0;
            rght_d  = 12'd0;
        end
    end

    always_comb begin
        drv_en_d = (state_d == StRun) || (state_d == StStop);
        fault_d  = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 16'd0;
            lft_q    <= 12'd0;
            rght_q   <= 12'd0;
            drv_en_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lft_q    <= lft_d;
            rght_q   <= rght_d;
            drv_en_q <= drv_en_d;
            fault_q  <= fault_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign drv_en   = drv_en_q;
    assign fault    = fault_q;

endmodule
